// File: rtl/activation_stream.sv
// rtl/activation_stream.sv - three-stage streaming activation unit (IDENTITY/RELU/GELU/LEAKY_RELU)
module activation_stream #(
   parameter int N_CH    = 16,
   parameter int WIDTH   = 8,
   parameter int CONST_W = 18,
   parameter int EMS     = 8,
   parameter int CNT_W   = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [N_CH-1:0][WIDTH-1:0]   data_i,
   input  logic [1:0]                   mode_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [N_CH-1:0][WIDTH-1:0]   data_o,
   input  logic                         cfg_we_i,
   input  logic [CONST_W-1:0]           one_i,
   input  logic [CONST_W-1:0]           b_i,
   input  logic [CONST_W-1:0]           c_i,
   input  logic [EMS-1:0]               eps_mult_i,
   input  logic [EMS-1:0]               right_shift_i,
   input  logic [WIDTH-1:0]             add_i,
   input  logic [2:0]                   leak_shift_i,
   output logic                         cfg_err_o,
   output logic                         busy_o,
   input  logic                         clr_cnt_i,
   output logic [CNT_W-1:0]             sat_cnt_o
);

   localparam logic [1:0] MODE_ID    = 2'd0;
   localparam logic [1:0] MODE_RELU  = 2'd1;
   localparam logic [1:0] MODE_GELU  = 2'd2;
   localparam logic [1:0] MODE_LEAKY = 2'd3;

   // Internal widths sized so that no GELU intermediate can wrap.
   localparam int AW  = CONST_W + 1;      // |x|, -b, a, a+b
   localparam int SQW = 2 * AW;           // (a+b)^2
   localparam int EW  = SQW + 2;          // erf and erf+one
   localparam int GW  = WIDTH + EW;       // g = x*(erf+one)
   localparam int PW  = GW + EMS + 1;     // g*eps_mult
   localparam int RW  = PW + 2;           // rounding sum, shifted result, +add
   localparam int SW  = $clog2(N_CH + 1); // clamped-lane count per beat

   localparam logic signed [RW-1:0] MAX_Y = RW'(2 ** (WIDTH - 1) - 1);
   localparam logic signed [RW-1:0] MIN_Y = -RW'(2 ** (WIDTH - 1));

   // Constants, only written while the pipeline is empty
   logic signed [CONST_W-1:0] r_one, r_b, r_c;
   logic [EMS-1:0]            r_eps, r_shift;
   logic signed [WIDTH-1:0]   r_add;
   logic [2:0]                r_leak;
   logic                      r_cfg_err;

   // Pipeline state
   logic                          r_v1, r_v2, r_v3;
   logic [N_CH-1:0][WIDTH-1:0]    r1_x, r2_x, r_y3;
   logic [N_CH-1:0]               r1_neg;
   logic signed [SQW-1:0]         r1_sq [N_CH];
   logic signed [GW-1:0]          r2_g  [N_CH];
   logic [1:0]                    r1_mode, r2_mode;
   logic [SW-1:0]                 r_nsat3;
   logic [CNT_W-1:0]              r_cnt;

   logic w_stall, w_cfg_ok;

   assign w_stall     = r_v3 & ~out_ready_i;
   assign in_ready_o  = ~w_stall;
   assign out_valid_o = r_v3;
   assign data_o      = r_y3;
   assign busy_o      = r_v1 | r_v2 | r_v3;
   assign cfg_err_o   = r_cfg_err;
   assign sat_cnt_o   = r_cnt;
   assign w_cfg_ok    = cfg_we_i & ~busy_o & ~in_valid_i;

   // Constant load when idle; a refused write pulses cfg_err_o for one cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_one     <= '0;
         r_b       <= '0;
         r_c       <= '0;
         r_eps     <= '0;
         r_shift   <= '0;
         r_add     <= '0;
         r_leak    <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= cfg_we_i & ~w_cfg_ok;
         if (w_cfg_ok) begin
            r_one   <= one_i;
            r_b     <= b_i;
            r_c     <= c_i;
            r_eps   <= eps_mult_i;
            r_shift <= right_shift_i;
            r_add   <= add_i;
            r_leak  <= leak_shift_i;
         end
      end
   end

   // S1: magnitude, clip to -b, and square of (a+b) per lane
   logic signed [AW-1:0]  w1_negb;
   logic signed [AW-1:0]  w1_abs [N_CH];
   logic signed [AW-1:0]  w1_a   [N_CH];
   logic signed [AW-1:0]  w1_d   [N_CH];
   logic signed [SQW-1:0] w1_sq  [N_CH];

   // S1 lane arithmetic
   always_comb begin
      w1_negb = -AW'(r_b);
      for (int i = 0; i < N_CH; i++) begin
         w1_abs[i] = data_i[i][WIDTH-1] ? -AW'($signed(data_i[i])) : AW'($signed(data_i[i]));
         w1_a[i]   = (w1_abs[i] < w1_negb) ? w1_abs[i] : w1_negb;
         w1_d[i]   = w1_a[i] + AW'(r_b);
         w1_sq[i]  = SQW'(w1_d[i]) * SQW'(w1_d[i]);
      end
   end

   // S2: signed erf approximation and g = x*(erf+one)
   logic signed [EW-1:0] w2_t  [N_CH];
   logic signed [EW-1:0] w2_e1 [N_CH];
   logic signed [GW-1:0] w2_g  [N_CH];

   // S2 lane arithmetic
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         w2_t[i]  = EW'(r1_sq[i]) + EW'(r_c);
         w2_e1[i] = (r1_neg[i] ? -w2_t[i] : w2_t[i]) + EW'(r_one);
         w2_g[i]  = GW'($signed(r2_x_in(i))) * GW'(w2_e1[i]);
      end
   end

   function automatic logic [WIDTH-1:0] r2_x_in(input int idx);
      return r1_x[idx];
   endfunction

   // S3: requantise and saturate GELU lanes, pass-through modes bypass it
   logic [31:0]             w3_shamt;
   logic signed [RW-1:0]    w3_rnd;
   logic signed [PW-1:0]    w3_p   [N_CH];
   logic signed [RW-1:0]    w3_sum [N_CH];
   logic signed [RW-1:0]    w3_r   [N_CH];
   logic signed [RW-1:0]    w3_q   [N_CH];
   logic signed [WIDTH-1:0] w3_x   [N_CH];
   logic [N_CH-1:0][WIDTH-1:0] w3_y;
   logic [N_CH-1:0]         w3_sat;
   logic [SW-1:0]           w3_nsat;

   // S3 lane arithmetic; shifts at or beyond the product width all give 0
   always_comb begin
      w3_shamt = (32'(r_shift) > 32'(PW)) ? 32'(PW) : 32'(r_shift);
      w3_rnd   = (r_shift != '0) ? (RW'(1) <<< (w3_shamt - 32'd1)) : '0;
      w3_nsat  = '0;
      for (int i = 0; i < N_CH; i++) begin
         w3_p[i]   = PW'(r2_g[i]) * PW'($signed({1'b0, r_eps}));
         w3_sum[i] = RW'(w3_p[i]) + w3_rnd;
         w3_r[i]   = w3_sum[i] >>> w3_shamt;
         w3_q[i]   = w3_r[i] + RW'(r_add);
         w3_x[i]   = $signed(r2_x[i]);
         w3_sat[i] = 1'b0;
         case (r2_mode)
            MODE_RELU:  w3_y[i] = (w3_x[i] < 0) ? '0 : w3_x[i];
            MODE_LEAKY: w3_y[i] = (w3_x[i] < 0) ? (w3_x[i] >>> r_leak) : w3_x[i];
            MODE_GELU: begin
               if (w3_q[i] > MAX_Y) begin
                  w3_y[i]   = WIDTH'(MAX_Y);
                  w3_sat[i] = 1'b1;
               end else if (w3_q[i] < MIN_Y) begin
                  w3_y[i]   = WIDTH'(MIN_Y);
                  w3_sat[i] = 1'b1;
               end else begin
                  w3_y[i]   = WIDTH'(w3_q[i]);
               end
            end
            default:    w3_y[i] = w3_x[i];
         endcase
         w3_nsat = w3_nsat + SW'(w3_sat[i]);
      end
   end

   // Stage valids and output register; the whole pipe holds while stalled
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_v3    <= 1'b0;
         r_y3    <= '0;
         r_nsat3 <= '0;
      end else if (!w_stall) begin
         r_v1 <= in_valid_i;
         r_v2 <= r_v1;
         r_v3 <= r_v2;
         if (r_v2) begin
            r_y3    <= w3_y;
            r_nsat3 <= w3_nsat;
         end
      end
   end

   // Datapath registers for S1/S2, qualified by their valids downstream
   always_ff @(posedge clk_i) begin
      if (!w_stall) begin
         r1_x    <= data_i;
         r1_mode <= mode_i;
         r2_x    <= r1_x;
         r2_mode <= r1_mode;
         for (int i = 0; i < N_CH; i++) begin
            r1_neg[i] <= data_i[i][WIDTH-1];
            r1_sq[i]  <= w1_sq[i];
            r2_g[i]   <= w2_g[i];
         end
      end
   end

   logic [CNT_W:0] w_cnt_sum;
   assign w_cnt_sum = (CNT_W + 1)'(r_cnt) + (CNT_W + 1)'(r_nsat3);

   // Saturation counter: add clamped lanes as a beat leaves, stick at max, clear wins
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_cnt_i) begin
         r_cnt <= '0;
      end else if (r_v3 && out_ready_i) begin
         r_cnt <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_activation_stream.sv
// tb/tb_activation_stream.sv - directed self-checking bench for activation_stream
module tb_activation_stream;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int CW = 18;
   localparam int E  = 8;
   localparam int CN = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, in_valid, in_ready, out_valid, out_ready, cfg_we, cfg_err, busy, clr;
   logic [N-1:0][W-1:0] din, dout;
   logic [1:0]  mode;
   logic [CW-1:0] one, b, c;
   logic [E-1:0] eps, sh;
   logic [W-1:0] add;
   logic [2:0]  leak;
   logic [CN-1:0] sat_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   activation_stream #(.N_CH(N), .WIDTH(W), .CONST_W(CW), .EMS(E), .CNT_W(CN)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .data_i(din), .mode_i(mode),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .data_o(dout),
      .cfg_we_i(cfg_we), .one_i(one), .b_i(b), .c_i(c),
      .eps_mult_i(eps), .right_shift_i(sh), .add_i(add), .leak_shift_i(leak),
      .cfg_err_o(cfg_err), .busy_o(busy), .clr_cnt_i(clr), .sat_cnt_o(sat_cnt)
   );

   function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
      return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_cfg(input int o, input int bb, input int cc, input int e,
                          input int s, input int a, input int l);
      one = CW'(o); b = CW'(bb); c = CW'(cc);
      eps = E'(e); sh = E'(s); add = W'(a); leak = 3'(l);
      cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
      chk("cfg_idle_err", 64'(cfg_err), 64'd0);
   endtask

   task automatic send(input logic [1:0] m, input logic [31:0] d);
      mode = m; din = d; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // called one cycle after the beat was presented; returns one cycle after it left
   task automatic drain_check(input string tag, input logic [31:0] exp);
      chk({tag, "_c1"}, 64'(out_valid), 64'd0);
      tick();
      chk({tag, "_c2"}, 64'(out_valid), 64'd0);
      tick();
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_data"}, 64'(dout), 64'(exp));
      tick();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cfg_we = 1'b0; clr = 1'b0;
      din = '0; mode = 2'd0; one = '0; b = '0; c = '0; eps = '0; sh = '0; add = '0; leak = '0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(dout), 64'd0);
      chk("rst_sat", 64'(sat_cnt), 64'd0);
      chk("rst_err", 64'(cfg_err), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);

      // basic GELU
      set_cfg(2, -4, 1, 1, 0, 0, 2);
      send(2'd2, pk(3, -3, 10, 0));
      drain_check("gelu1", pk(12, 0, 30, 0));
      chk("gelu1_gone", 64'(out_valid), 64'd0);
      chk("sat_after1", 64'(sat_cnt), 64'd0);

      // positive saturation, negative passes
      send(2'd2, pk(100, -100, 3, -3));
      drain_check("gelu_sat", pk(127, -100, 12, 0));
      chk("sat_after2", 64'(sat_cnt), 64'd1);

      // negative clamp through add offset
      set_cfg(2, -4, 1, 1, 0, -40, 2);
      send(2'd2, pk(100, -100, 3, 0));
      drain_check("gelu_clamp", pk(127, -128, -28, -40));
      chk("sat_after3", 64'(sat_cnt), 64'd3);

      // requant with rounding shift and offset
      set_cfg(2, -4, 1, 3, 2, 1, 2);
      send(2'd2, pk(3, 0, -100, 10));
      drain_check("gelu_rq", pk(10, 1, -74, 24));
      chk("sat_after4", 64'(sat_cnt), 64'd3);

      // back-to-back mixed modes, then stall
      din = pk(-7, 5, -8, 0); in_valid = 1'b1;
      mode = 2'd0; tick();
      mode = 2'd1; tick();
      mode = 2'd3; tick();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("mix_id_valid", 64'(out_valid), 64'd1);
      chk("mix_id_data", 64'(dout), 64'(pk(-7, 5, -8, 0)));
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_ready", 64'(in_ready), 64'd0);
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_data", 64'(dout), 64'(pk(-7, 5, -8, 0)));
      end
      out_ready = 1'b1;
      #1;
      chk("unstall_ready", 64'(in_ready), 64'd1);
      tick();
      chk("mix_relu_valid", 64'(out_valid), 64'd1);
      chk("mix_relu_data", 64'(dout), 64'(pk(0, 5, 0, 0)));
      tick();
      chk("mix_leaky_valid", 64'(out_valid), 64'd1);
      chk("mix_leaky_data", 64'(dout), 64'(pk(-2, 5, -2, 0)));
      tick();
      chk("mix_done", 64'(out_valid), 64'd0);
      chk("mix_idle", 64'(busy), 64'd0);

      // config write refused while a beat is entering / in flight
      mode = 2'd2; din = pk(3, 0, -100, 10); in_valid = 1'b1;
      one = CW'(5); b = CW'(-4); c = CW'(1); eps = 8'd1; sh = 8'd0; add = 8'd0;
      cfg_we = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("cfg_rej_in", 64'(cfg_err), 64'd1);
      tick();
      cfg_we = 1'b0;
      chk("cfg_rej_busy", 64'(cfg_err), 64'd1);
      tick();
      chk("cfg_rej_clear", 64'(cfg_err), 64'd0);
      chk("old_cfg_valid", 64'(out_valid), 64'd1);
      chk("old_cfg_data", 64'(dout), 64'(pk(10, 1, -74, 24)));
      tick();
      set_cfg(2, -4, 1, 1, 0, 0, 2);
      send(2'd2, pk(3, -3, 10, 0));
      drain_check("new_cfg", pk(12, 0, 30, 0));

      // reset with two beats in flight
      mode = 2'd0; din = pk(1, 2, 3, 4); in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0; rst = 1'b1;
      tick();
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_sat", 64'(sat_cnt), 64'd0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("post_rst_quiet", 64'(out_valid), 64'd0);
      end

      // counter sticks at its maximum
      set_cfg(2, -4, 1, 1, 0, 0, 2);
      mode = 2'd2; din = pk(100, 100, 100, 100); in_valid = 1'b1;
      repeat (4) tick();
      in_valid = 1'b0;
      chk("cnt_4", 64'(sat_cnt), 64'd4);
      tick();
      chk("cnt_8", 64'(sat_cnt), 64'd8);
      tick();
      chk("cnt_12", 64'(sat_cnt), 64'd12);
      tick();
      chk("cnt_max", 64'(sat_cnt), 64'd15);
      tick();
      chk("cnt_hold", 64'(sat_cnt), 64'd15);

      // clear coinciding with a saturating beat leaving
      send(2'd2, pk(100, -3, 3, 0));
      tick();
      tick();
      chk("clr_beat_valid", 64'(out_valid), 64'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_wins", 64'(sat_cnt), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
